// File: rtl/crc_pkg.sv
// Shared definitions for the bit-serial CRC-8 engine: FSM states, width and default polynomial.
package crc_pkg;

  localparam int unsigned CRC8_WIDTH = 8;
  localparam logic [CRC8_WIDTH-1:0] CRC8_POLY_DEFAULT = 8'h07;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc8_lfsr_step.sv
// One combinational CRC-8 LFSR step; one XOR gate per set tap of POLY plus the feedback gate.
module crc8_lfsr_step
  import crc_pkg::*;
#(
  parameter logic [CRC8_WIDTH-1:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [CRC8_WIDTH-1:0] crc,
  input  logic                  din,
  output logic [CRC8_WIDTH-1:0] crc_next
);

  logic                  fb;
  logic [CRC8_WIDTH-1:0] shifted;

  assign shifted = {crc[CRC8_WIDTH-2:0], 1'b0};

  xor2 u_fb (
    .a(crc[CRC8_WIDTH-1]),
    .b(din),
    .y(fb)
  );

  for (genvar i = 0; i < CRC8_WIDTH; i++) begin : g_tap
    if (POLY[i]) begin : g_xor
      xor2 u_tap (
        .a(shifted[i]),
        .b(fb),
        .y(crc_next[i])
      );
    end else begin : g_pass
      assign crc_next[i] = shifted[i];
    end
  end

endmodule

// File: rtl/xor2.sv
// Team two-input XOR gate primitive.
module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine with frame FSM, bit counter and sticky overflow.
// Optional residue compare output crc_err is built when CRC8_SERIAL_RESIDUE_CHECK_EN is defined.
module crc8_serial
  import crc_pkg::*;
#(
  parameter logic [CRC8_WIDTH-1:0] POLY     = CRC8_POLY_DEFAULT,
  parameter logic [CRC8_WIDTH-1:0] INIT     = 8'h00,
  parameter int unsigned           MAX_BITS = 64,
  localparam int unsigned          CW       = $clog2(MAX_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  last,
  output logic [CRC8_WIDTH-1:0] crc_out,
  output logic                  crc_valid,
  output logic                  busy,
  output logic [CW-1:0]         bit_count,
  output logic                  overflow
`ifdef CRC8_SERIAL_RESIDUE_CHECK_EN
  ,
  output logic                  crc_err
`endif
);

  crc_state_e state_q, state_d;

  logic [CRC8_WIDTH-1:0] crc_q, crc_d, crc_step;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  take_bit;
  logic                  at_max;

  assign take_bit = (state_q == StRun) && din_valid && !start;
  assign at_max   = (cnt_q == CW'(MAX_BITS));

  crc8_lfsr_step #(
    .POLY(POLY)
  ) u_step (
    .crc     (crc_q),
    .din     (din),
    .crc_next(crc_step)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start overrides every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StRun:   if (din_valid && last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d = StRun;
    end
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    busy      = 1'b0;
    crc_valid = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StRun:   busy = 1'b1;
      StDone:  crc_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    crc_d = crc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (start) begin
      crc_d = INIT;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (take_bit) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else begin
        crc_d = crc_step;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= INIT;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign crc_out   = crc_q;
  assign bit_count = cnt_q;
  assign overflow  = ovf_q;

`ifdef CRC8_SERIAL_RESIDUE_CHECK_EN
  logic err_q, err_d;

  // Compare the remainder as it will stand in the DONE cycle
  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = 1'b0;
    end else if (take_bit && last) begin
      err_d = (crc_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign crc_err = err_q;
`endif

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: two instances (MAX_BITS 80 and 8) share one stimulus stream.
module tb_crc8_serial;

  logic clk = 1'b0;
  logic rst_n, start, din, din_valid, last;

  logic [7:0] crc80, crc8;
  logic       v80, v8, busy80, busy8, ovf80, ovf8;
  logic [6:0] cnt80;
  logic [3:0] cnt8;
`ifdef CRC8_SERIAL_RESIDUE_CHECK_EN
  logic       err80, err8;
`endif

  always #5 clk = ~clk;

  crc8_serial #(.MAX_BITS(80)) dut80 (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid), .last(last),
    .crc_out(crc80), .crc_valid(v80), .busy(busy80), .bit_count(cnt80), .overflow(ovf80)
`ifdef CRC8_SERIAL_RESIDUE_CHECK_EN
    , .crc_err(err80)
`endif
  );

  crc8_serial #(.MAX_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid), .last(last),
    .crc_out(crc8), .crc_valid(v8), .busy(busy8), .bit_count(cnt8), .overflow(ovf8)
`ifdef CRC8_SERIAL_RESIDUE_CHECK_EN
    , .crc_err(err8)
`endif
  );

  int total = 0;
  int passed = 0;
  int vcnt = 0;
  int frames = 0;
  logic fbits [0:127];

  always @(negedge clk) if (v80) vcnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic l);
    din = b; din_valid = 1'b1; last = l;
    tick();
    din_valid = 1'b0; last = 1'b0; din = 1'b0;
  endtask

  // Reference: polynomial long division of M(x)*x^8 by x^8+x^2+x+1 (INIT = 0)
  function automatic logic [7:0] ref_crc(input int n);
    logic a [0:135];
    logic [8:0] g;
    logic [7:0] r;
    g = 9'h107;
    for (int i = 0; i < 136; i++) a[i] = (i < n) ? fbits[i] : 1'b0;
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 9; j++) a[i+j] = a[i+j] ^ g[8-j];
    for (int k = 0; k < 8; k++) r[7-k] = a[n+k];
    return r;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic load_byte(input int pos, input logic [7:0] v);
    for (int k = 0; k < 8; k++) fbits[pos+k] = v[7-k];
  endtask

  // Sends fbits[0:n-1] after a start; returns positioned in the DONE cycle
  task automatic run_frame(input int n, input bit gaps);
    do_start();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) tick();
      send_bit(fbits[i], i == n - 1);
    end
    frames++;
  endtask

  task automatic check_done(input string nm, input int n, input logic [7:0] e80,
                            input logic [7:0] e8);
    chk({nm, ".valid80"}, v80, 1);
    chk({nm, ".valid8"}, v8, 1);
    chk({nm, ".busy80"}, busy80, 0);
    chk({nm, ".crc80"}, crc80, e80);
    chk({nm, ".crc8"}, crc8, e8);
    chk({nm, ".cnt80"}, cnt80, min_i(n, 80));
    chk({nm, ".cnt8"}, cnt8, min_i(n, 8));
    chk({nm, ".ovf80"}, ovf80, n > 80);
    chk({nm, ".ovf8"}, ovf8, n > 8);
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic [7:0] exp_crc;
  } vec_t;

  initial begin
    vec_t vecs [6];
    string s;
    int vbase, n;
    logic [7:0] hold;

    vecs[0] = '{8'h01, 8, 8'h07};
    vecs[1] = '{8'h00, 8, 8'h00};
    vecs[2] = '{8'hFF, 8, 8'hF3};
    vecs[3] = '{8'h80, 8, 8'h89};
    vecs[4] = '{8'h01, 4, 8'h07};
    vecs[5] = '{8'h02, 8, 8'h0E};

    rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0; last = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst.crc", crc80, 8'h00);
    chk("rst.busy", busy80, 0);
    chk("rst.cnt", cnt80, 0);
    chk("rst.valid", v80, 0);
    chk("rst.ovf", ovf8, 0);

    // din_valid in IDLE is ignored
    send_bit(1'b1, 1'b1);
    chk("idle.cnt", cnt80, 0);
    chk("idle.busy", busy80, 0);

    // Reset mid-frame
    vbase = vcnt;
    do_start();
    chk("start.busy", busy80, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("mid.cnt", cnt80, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.crc", crc80, 8'h00);
    chk("midrst.busy", busy80, 0);
    chk("midrst.cnt", cnt80, 0);
    tick();
    chk("midrst.novalid", vcnt, vbase);

    // Table-driven single frames
    foreach (vecs[t]) begin
      hold = vecs[t].data;
      for (int k = 0; k < vecs[t].nbits; k++) fbits[k] = hold[vecs[t].nbits-1-k];
      run_frame(vecs[t].nbits, 1'b0);
      check_done($sformatf("vec%0d", t), vecs[t].nbits, vecs[t].exp_crc, vecs[t].exp_crc);
      tick();
      chk($sformatf("vec%0d.pulse", t), v80, 0);
      chk($sformatf("vec%0d.hold", t), crc80, vecs[t].exp_crc);
    end

    // "123456789" then back-to-back frame started in the DONE cycle
    s = "123456789";
    for (int i = 0; i < 9; i++) load_byte(8 * i, s[i]);
    run_frame(72, 1'b0);
    check_done("check", 72, 8'hF4, ref_crc(8));
    load_byte(0, 8'h01);
    run_frame(8, 1'b0);
    check_done("b2b", 8, 8'h07, 8'h07);

    // Abort plus start/din_valid collision
    tick();
    do_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    vbase = vcnt;
    start = 1'b1; din = 1'b1; din_valid = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
    chk("coll.cnt", cnt80, 0);
    chk("coll.crc", crc80, 8'h00);
    chk("coll.novalid", vcnt, vbase);
    for (int i = 0; i < 8; i++) send_bit(fbits[i], i == 7);
    frames++;
    check_done("abort", 8, 8'h07, 8'h07);

    // Overflow on the 8-bit instance: ninth bit carries last
    load_byte(0, 8'h01);
    fbits[8] = 1'b1;
    run_frame(9, 1'b0);
    check_done("ovf", 9, ref_crc(9), 8'h07);
    tick();
    chk("ovf.sticky", ovf8, 1);
    do_start();
    chk("ovf.clear", ovf8, 0);
    send_bit(1'b0, 1'b1);
    frames++;
    tick();

    // Randomized frames against the long-division model
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 90);
      for (int i = 0; i < n; i++) fbits[i] = 1'($urandom_range(0, 1));
      run_frame(n, 1'b1);
      check_done($sformatf("rnd%0d", f), n, ref_crc(min_i(n, 80)), ref_crc(min_i(n, 8)));
      repeat ($urandom_range(1, 3)) tick();
    end

`ifdef CRC8_SERIAL_RESIDUE_CHECK_EN
    for (int i = 0; i < 9; i++) load_byte(8 * i, s[i]);
    load_byte(72, 8'hF4);
    run_frame(80, 1'b0);
    chk("res.crc", crc80, 8'h00);
    chk("res.err", err80, 0);
    fbits[13] = ~fbits[13];
    run_frame(80, 1'b0);
    chk("res.flip", err80, 1);
    tick();
    chk("res.hold", err80, 1);
    do_start();
    chk("res.clear", err80, 0);
    send_bit(1'b0, 1'b1);
    frames++;
    tick();
`endif

    tick();
    chk("pulse.count", vcnt, frames);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crc8_serial.md
# crc8_serial

Bit-serial CRC-8 engine built from the team's XOR gate primitives: it consumes one data bit per cycle from the upstream serial source and folds it into an 8-bit LFSR remainder. It sits directly downstream of the XOR/parity stage in the Lab 6 datapath. It delivers a finished remainder with a one-cycle valid pulse at frame end.

## Interface
- POLY, 8'h07, generator polynomial with implicit x^8; bit i set means tap x^i
- INIT, 8'h00, remainder value loaded on start
- MAX_BITS, 64, maximum accepted data bits per frame
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  loads INIT and opens a frame
- din  input  1  serial data bit, MSB first
- din_valid  input  1  din is valid this cycle
- last  input  1  qualifies din as the final bit of the frame; ignored unless din_valid
- crc_out  output  8  current remainder; holds its value after the frame until the next start
- crc_valid  output  1  one-cycle pulse when crc_out is final
- busy  output  1  high while a frame is open (RUN state)
- bit_count  output  $clog2(MAX_BITS+1)  data bits accepted in the current frame
- overflow  output  1  sticky flag: a bit arrived after MAX_BITS bits were accepted

## Operation
- States:
  - IDLE: reset state; din_valid is ignored.
  - RUN: frame open; busy=1.
  - DONE: lasts exactly one cycle; crc_valid=1, then returns to IDLE.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE on din_valid&last.
  - DONE→IDLE unconditionally, unless start is asserted; then DONE→RUN.
- Bit update on accepted bit: fb = crc[7]^din; crc ← {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
  - bit_count increments by 1 per accepted bit.
- start in any state clears bit_count and overflow, loads INIT, and enters RUN.
  - start mid-frame aborts the frame; no crc_valid is produced.
- start and din_valid in the same cycle: start wins and the bit is discarded.
- If bit_count==MAX_BITS and din_valid is high: the bit is not folded and overflow sets.
  - If last is also set, the frame still closes to DONE.
- rst_n low at any clock edge, including mid-frame, returns the block to IDLE. All outputs take their reset values.
- Reset values:
  - crc_out=INIT
  - crc_valid=0
  - busy=0
  - bit_count=0
  - overflow=0
  - crc_err=0 (when compiled in)

## Timing
- start sampled at edge n: crc_out=INIT and busy=1 from cycle n+1.
- Accepted bit at edge n: the updated crc_out is visible in cycle n+1. Throughput is one bit per clock with no stall.
- last bit at edge n:
  - crc_out is final and crc_valid=1 during cycle n+1 only.
  - busy drops in cycle n+1.
- Minimum gap from last to the next frame's first bit: start at edge n+1, then first din_valid at edge n+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CRC8_SERIAL_RESIDUE_CHECK_EN
- With the macro defined:
  - Adds output crc_err (1 bit), registered, updated in the same cycle as crc_valid.
  - crc_err=1 iff the final remainder is not 8'h00. This holds for frames carrying their appended CRC, with INIT=0.
  - crc_err holds its value until the next start, which clears it.
- Without the macro: the port does not exist and no compare logic is built.

## Structure
- Shared package crc_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the default polynomial constant CRC8_POLY_DEFAULT=8'h07
  - CRC8_WIDTH=8
- Sub-module crc8_lfsr_step: purely combinational.
  - Inputs: 8-bit crc, din, POLY.
  - Output: next crc.
  - Taps are implemented as instances of the team XOR gate, one per set bit of POLY, generated.
- The top level holds the FSM, the counter, the overflow flag and the output registers.

## Test plan
- Reset mid-frame: start, 5 bits, then rst_n=0 for one edge → crc_out=00, busy=0, bit_count=0, no crc_valid.
- Single byte 0x01, MSB first, last on bit 8 → crc_out=0x07, crc_valid high for exactly one cycle, bit_count=8.
- ASCII "123456789" (72 bits) with MAX_BITS=80 → crc_out=0xF4. Then assert start in the DONE cycle → back-to-back frame is accepted.
- Abort and collision: start, 3 bits, then start+din_valid in the same cycle, then byte 0x01 → crc_out=0x07, bit_count=8, no crc_valid between the two starts.
- Overflow with MAX_BITS=8: 9 bits, the 9th with last → overflow=1, crc_out equals the 8-bit result, crc_valid pulses.
- Residue check, with CRC8_SERIAL_RESIDUE_CHECK_EN defined:
  - "123456789" followed by 0xF4 → crc_out=00, crc_err=0.
  - The same frame with one bit flipped → crc_err=1.
